// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared definitions for the 64x8 RAM request front-end.
//   ADDR_W_DFLT / DATA_W_DFLT : default RAM address / data widths
//   ST_*                      : FSM state encodings (IDLE, WR, RD, CAP, RSP)
//   state_e                   : enum view of the same encodings
//   req_lat_t                 : request captured on accept {wr, addr, data}
package ram_ctrl_pkg;

    localparam int unsigned ADDR_W_DFLT = 6;
    localparam int unsigned DATA_W_DFLT = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_CAP  = 3'd3;
    localparam logic [2:0] ST_RSP  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_WR   = ST_WR,
        S_RD   = ST_RD,
        S_CAP  = ST_CAP,
        S_RSP  = ST_RSP
    } state_e;

    typedef struct packed {
        logic                   wr;
        logic [ADDR_W_DFLT-1:0] addr;
        logic [DATA_W_DFLT-1:0] data;
    } req_lat_t;

endpackage

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: request front-end for a 64x8 synchronous RAM with registered dout.
// Accepts one read/write request at a time, drives the RAM pins, waits out the
// one-cycle read latency and returns read data on a valid/ready channel.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset (shared with RAM)
//   req_valid_i / req_ready_o    request handshake
//   req_wr_i, req_addr_i, req_data_i  request payload (data ignored for reads)
//   rsp_valid_o / rsp_ready_i    response handshake, rsp_data_o read data
//   ram_wr_o, ram_addr_o, ram_din_o, ram_dout_i  RAM pin interface
//   rb_err_o                     sticky write-readback mismatch (0 without the feature)
// Build option: define RAM_REQ_CTRL_READBACK_EN to read back every write and
// flag mismatches on rb_err_o.
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DFLT,
    parameter int unsigned DATA_W = DATA_W_DFLT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_wr_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              ram_wr_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic              rb_err_o
);

`ifdef RAM_REQ_CTRL_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    logic [2:0]        state_q,     state_d;
    req_lat_t          lat_q,       lat_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              ram_wr_q,    ram_wr_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_din_q,   ram_din_d;

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ram_wr_q    <= ram_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
        end
    end

    // Next-state and next-output logic; outputs are set one state ahead so the
    // registered pins line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        ram_wr_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    lat_d.wr    = req_wr_i;
                    lat_d.addr  = ADDR_W_DFLT'(req_addr_i);
                    lat_d.data  = DATA_W_DFLT'(req_data_i);
                    req_ready_d = 1'b0;
                    ram_addr_d  = req_addr_i;
                    if (req_wr_i) begin
                        ram_wr_d  = 1'b1;
                        ram_din_d = req_data_i;
                        state_d   = ST_WR;
                    end else begin
                        state_d   = ST_RD;
                    end
                end
            end
            ST_WR: begin
                // With readback the same address is read straight after the write
                ram_addr_d  = ADDR_W'(lat_q.addr);
                ram_din_d   = DATA_W'(lat_q.data);
                state_d     = RB_EN ? ST_RD : ST_IDLE;
                req_ready_d = !RB_EN;
            end
            ST_RD: begin
                ram_addr_d = ADDR_W'(lat_q.addr);
                state_d    = ST_CAP;
            end
            ST_CAP: begin
                if (RB_EN && lat_q.wr) begin
                    // Write readback: checked below, never reported as a response
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    rsp_data_d  = ram_dout_i;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

`ifdef RAM_REQ_CTRL_READBACK_EN
    logic rb_err_q;

    // Sticky readback mismatch flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rb_err_q <= 1'b0;
        end else if (state_q == ST_CAP && lat_q.wr && ram_dout_i != DATA_W'(lat_q.data)) begin
            rb_err_q <= 1'b1;
        end
    end

    assign rb_err_o = rb_err_q;
`else
    assign rb_err_o = 1'b0;
`endif

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign ram_wr_o    = ram_wr_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_din_o   = ram_din_q;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb_ram_req_ctrl: directed bench for ram_req_ctrl with a 64x8 RAM model on the
// same clk/rst. A transaction-level model (memory array + cycles since accept)
// predicts every output each cycle; directed steps add literal expectations.
// Define RAM_REQ_CTRL_READBACK_EN for both RTL and bench to exercise readback.
module tb_ram_req_ctrl;

`ifdef RAM_REQ_CTRL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_wr = 1'b0;
    logic [5:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       rsp_ready = 1'b0;
    logic       req_ready, rsp_valid, ram_wr, rb_err;
    logic [7:0] rsp_data, ram_din, ram_dout;
    logic [5:0] ram_addr;
    logic       force_zero = 1'b0;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ram_req_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_wr_i    (req_wr),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .ram_wr_o    (ram_wr),
        .ram_addr_o  (ram_addr),
        .ram_din_o   (ram_din),
        .ram_dout_i  (ram_dout),
        .rb_err_o    (rb_err)
    );

    // 64x8 synchronous RAM: registered dout, contents cleared by rst
    logic [7:0] ram_mem [64];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= '0;
            ram_q <= '0;
        end else begin
            if (ram_wr) ram_mem[ram_addr] <= ram_din;
            ram_q <= ram_mem[ram_addr];
        end
    end
    assign ram_dout = force_zero ? 8'h00 : ram_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: expected pins derived from accept time and memory contents
    logic       m_ready = 1'b1, m_rsp_valid = 1'b0, m_ram_wr = 1'b0, m_rb_err = 1'b0;
    logic [7:0] m_rsp_data = '0, m_ram_din = '0;
    logic [5:0] m_ram_addr = '0;
    logic [7:0] m_mem [64];
    int         age = -1;
    logic       t_wr = 1'b0;
    logic [5:0] t_addr = '0;
    logic [7:0] t_data = '0;

    initial begin
        logic [7:0] seen;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_ready = 1'b1; m_rsp_valid = 1'b0; m_rsp_data = '0;
                m_ram_wr = 1'b0; m_ram_addr = '0; m_ram_din = '0; m_rb_err = 1'b0;
                age = -1;
                for (int i = 0; i < 64; i++) m_mem[i] = '0;
            end else begin
                if (m_ram_wr) m_mem[m_ram_addr] = m_ram_din;
                if (age < 0) begin
                    if (req_valid) begin
                        age = 1;
                        t_wr = req_wr; t_addr = req_addr; t_data = req_data;
                        m_ready = 1'b0;
                        m_ram_addr = req_addr;
                        if (req_wr) begin
                            m_ram_wr = 1'b1;
                            m_ram_din = req_data;
                        end
                    end
                end else begin
                    m_ram_wr = 1'b0;
                    if (t_wr && !RB) begin
                        age = -1;
                        m_ready = 1'b1;
                    end else if (age < 3) begin
                        if (age == 2 && !t_wr) begin
                            m_rsp_valid = 1'b1;
                            m_rsp_data = m_mem[t_addr];
                        end
                        age++;
                    end else if (t_wr) begin
                        seen = force_zero ? 8'h00 : m_mem[t_addr];
                        if (seen != t_data) m_rb_err = 1'b1;
                        age = -1;
                        m_ready = 1'b1;
                    end else if (rsp_ready) begin
                        m_rsp_valid = 1'b0;
                        m_ready = 1'b1;
                        age = -1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("req_ready", 32'(req_ready), 32'(m_ready));
                chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
                chk("rsp_data",  32'(rsp_data),  32'(m_rsp_data));
                chk("ram_wr",    32'(ram_wr),    32'(m_ram_wr));
                chk("ram_addr",  32'(ram_addr),  32'(m_ram_addr));
                chk("ram_din",   32'(ram_din),   32'(m_ram_din));
                chk("rb_err",    32'(rb_err),    32'(m_rb_err));
            end
        end
    end

    // Present a request from a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic wr, input logic [5:0] a, input logic [7:0] d);
        int n = 0;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_data = d;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: req_ready still 0 after %0d cycles", n);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid still 0 after %0d cycles", n);
        end
    endtask

    initial begin
        int n;
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_ram_wr",    32'(ram_wr),    32'h0);
        chk("rst_ram_addr",  32'(ram_addr),  32'h0);
        chk("rst_rb_err",    32'(rb_err),    32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Read of cleared RAM, response held off until rsp_ready
        send(1'b0, 6'd5, 8'h00);
        chk("rd5_ready_low", 32'(req_ready), 32'h0);
        wait_rsp(n);
        chk("rd5_latency", 32'(n), 32'd2);
        chk("rd5_data", 32'(rsp_data), 32'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rd5_hold_ready", 32'(req_ready), 32'h0);
            chk("rd5_hold_valid", 32'(rsp_valid), 32'h1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rd5_done_valid", 32'(rsp_valid), 32'h0);
        chk("rd5_done_ready", 32'(req_ready), 32'h1);

        // Write 0xA5 @12 then read back
        send(1'b1, 6'd12, 8'hA5);
        chk("wr12_ram_wr",   32'(ram_wr),   32'h1);
        chk("wr12_ram_addr", 32'(ram_addr), 32'd12);
        chk("wr12_ram_din",  32'(ram_din),  32'hA5);
        @(negedge clk);
        chk("wr12_wr_pulse", 32'(ram_wr), 32'h0);
        chk("wr12_ready",    32'(req_ready), RB ? 32'h0 : 32'h1);
        send(1'b0, 6'd12, 8'h00);
        wait_rsp(n);
        chk("rd12_data", 32'(rsp_data), 32'hA5);
        @(negedge clk);

        // Address extremes, no aliasing
        send(1'b1, 6'd63, 8'h3C);
        send(1'b1, 6'd0,  8'hC3);
        send(1'b0, 6'd63, 8'h00);
        wait_rsp(n);
        chk("rd63_data", 32'(rsp_data), 32'h3C);
        @(negedge clk);
        send(1'b0, 6'd0, 8'h00);
        wait_rsp(n);
        chk("rd0_data", 32'(rsp_data), 32'hC3);
        @(negedge clk);

        // Stall in RSP with a competing request pending
        rsp_ready = 1'b0;
        send(1'b0, 6'd12, 8'h00);
        wait_rsp(n);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 6'd12; req_data = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'h1);
            chk("stall_data",  32'(rsp_data),  32'hA5);
            chk("stall_ready", 32'(req_ready), 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_rel_valid", 32'(rsp_valid), 32'h0);
        chk("stall_rel_ready", 32'(req_ready), 32'h1);
        rsp_ready = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        send(1'b0, 6'd12, 8'h00);
        wait_rsp(n);
        chk("rd12_after_stall", 32'(rsp_data), 32'hA5);
        @(negedge clk);

        // Reset while a response is pending; RAM is cleared too
        rsp_ready = 1'b0;
        send(1'b0, 6'd63, 8'h00);
        wait_rsp(n);
        chk("rd63_pre_rst", 32'(rsp_data), 32'h3C);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 32'(rsp_valid), 32'h0);
        chk("rst_mid_ready", 32'(req_ready), 32'h1);
        chk("rst_mid_data",  32'(rsp_data),  32'h00);
        rst = 1'b0;
        rsp_ready = 1'b1;
        send(1'b0, 6'd63, 8'h00);
        wait_rsp(n);
        chk("rd63_post_rst", 32'(rsp_data), 32'h00);
        @(negedge clk);

`ifdef RAM_REQ_CTRL_READBACK_EN
        // Good readback: no error, no response
        send(1'b1, 6'd7, 8'h55);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rb_ok_no_rsp", 32'(rsp_valid), 32'h0);
        end
        chk("rb_ok_err", 32'(rb_err), 32'h0);
        // Corrupted readback sets the sticky flag
        force_zero = 1'b1;
        send(1'b1, 6'd8, 8'h66);
        repeat (5) @(negedge clk);
        force_zero = 1'b0;
        chk("rb_bad_err", 32'(rb_err), 32'h1);
        send(1'b1, 6'd9, 8'h11);
        repeat (4) @(negedge clk);
        chk("rb_sticky", 32'(rb_err), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rb_rst_clear", 32'(rb_err), 32'h0);
        rst = 1'b0;
`else
        chk("rb_err_tied", 32'(rb_err), 32'h0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
